i2c_register_slave: RTL and testbench

- I2C write-only slave (responder) that receives the same transaction format our I2C master issues:
  - START, address byte (write), register byte, 16-bit data (MSB byte first), STOP.
- Each received 16-bit word is presented as a one-cycle register-write strobe.
- Used as an on-board camera-register model for system simulation, and as a control port so an external host can program FPGA configuration registers over the camera I2C pins.
- SCL/SDA are sampled from `clk`. The block drives SDA only by pulling it low (open drain); it never drives SCL.

---
 rtl/i2c_register_slave.sv | 151 +++++++++++++++
 tb/tb_i2c_register_slave.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_register_slave.sv
// Write-only I2C responder: START, address(W), register, 16-bit word (MSB first), STOP.
// Each complete word becomes a one-clk write strobe; the register index auto-increments per word.
module i2c_register_slave #(
  parameter logic [6:0] SlaveAddress = 7'h48,
  parameter int         SyncStages   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_drive_low,
  output logic        write_strobe,
  output logic [7:0]  write_register,
  output logic [15:0] write_data,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DHI, DHI_ACK, DLO, DLO_ACK, IGNORE
  } state_t;

  state_t state, state_next;
  logic   drive_next;

  logic [SyncStages-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_prev, sda_prev;
  logic scl_rise, scl_fall, start_cond, stop_cond;
  logic data_state, in_ack, byte_done, ack_exit;

  logic [7:0] shift_reg, full_byte, reg_index, high_byte;
  logic [2:0] bit_cnt;

  // Synchronizers idle high so a reset never fabricates a bus edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SyncStages-2:0], scl_in};
      sda_sync <= {sda_sync[SyncStages-2:0], sda_in};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end

  assign scl_s      = scl_sync[SyncStages-1];
  assign sda_s      = sda_sync[SyncStages-1];
  assign scl_rise   = scl_s && !scl_prev;
  assign scl_fall   = !scl_s && scl_prev;
  assign start_cond = scl_s && scl_prev && sda_prev && !sda_s;
  assign stop_cond  = scl_s && scl_prev && !sda_prev && sda_s;

  assign data_state = (state == ADDR) || (state == REG) || (state == DHI) || (state == DLO);
  assign in_ack     = (state == ADDR_ACK) || (state == REG_ACK) || (state == DHI_ACK) || (state == DLO_ACK);
  assign full_byte  = {shift_reg[6:0], sda_s};
  assign byte_done  = data_state && scl_rise && (bit_cnt == 3'd7) && !start_cond && !stop_cond;
  assign ack_exit   = in_ack && scl_fall && sda_drive_low && !start_cond && !stop_cond;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      sda_drive_low <= 1'b0;
    end else begin
      state         <= state_next;
      sda_drive_low <= drive_next;
    end
  end

  // sda_drive_low doubles as the ACK phase flag: the first fall asserts it, the second releases and advances.
  always_comb begin
    state_next = state;
    drive_next = sda_drive_low;
    if (start_cond) begin
      state_next = ADDR;
      drive_next = 1'b0;
    end else if (stop_cond) begin
      state_next = IDLE;
      drive_next = 1'b0;
    end else begin
      case (state)
        ADDR: if (byte_done)
                state_next = (full_byte[7:1] == SlaveAddress && !full_byte[0]) ? ADDR_ACK : IGNORE;
        REG:  if (byte_done) state_next = REG_ACK;
        DHI:  if (byte_done) state_next = DHI_ACK;
        DLO:  if (byte_done) state_next = DLO_ACK;
        ADDR_ACK, REG_ACK, DHI_ACK, DLO_ACK: begin
          if (scl_fall) begin
            if (!sda_drive_low) begin
              drive_next = 1'b1;
            end else begin
              drive_next = 1'b0;
              case (state)
                ADDR_ACK: state_next = REG;
                REG_ACK:  state_next = DHI;
                default:  state_next = (state == DHI_ACK) ? DLO : DHI;
              endcase
            end
          end
        end
        IGNORE:  drive_next = 1'b0;
        default: drive_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_reg      <= '0;
      bit_cnt        <= '0;
      reg_index      <= '0;
      high_byte      <= '0;
      write_strobe   <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
      busy           <= 1'b0;
    end else begin
      write_strobe <= 1'b0;
      if (start_cond) begin
        busy    <= 1'b1;
        bit_cnt <= '0;
      end else if (stop_cond) begin
        busy    <= 1'b0;
        bit_cnt <= '0;
      end else begin
        if (data_state && scl_rise) begin
          shift_reg <= full_byte;
          bit_cnt   <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          case (state)
            REG: reg_index <= full_byte;
            DHI: high_byte <= full_byte;
            DLO: begin
              write_strobe   <= 1'b1;
              write_data     <= {high_byte, full_byte};
              write_register <= reg_index;
            end
            default: ;
          endcase
        end
        if (ack_exit) begin
          bit_cnt <= '0;
          if (state == DLO_ACK) reg_index <= reg_index + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_register_slave.sv
// Self-checking bench for i2c_register_slave: a bit-banged I2C master, a table of transfers,
// and a scoreboard of expected register writes compared whenever the DUT strobes.
module tb_i2c_register_slave;

   localparam int HALF  = 10;
   localparam int SETUP = 6;

   typedef struct {
      int          nbytes;
      logic [63:0] bytes;
      logic [7:0]  ack_mask;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        scl_m = 1'b1;
   logic        sda_m = 1'b1;
   logic        scl_in, sda_in;
   logic        sda_drive_low, write_strobe, busy;
   logic [7:0]  write_register;
   logic [15:0] write_data;

   int          n_vectors = 0;
   int          n_miscompares = 0;
   logic [23:0] exp_q[$];
   logic [23:0] last_word = 24'h0;
   vec_t        vecs[7];

   assign scl_in = scl_m;
   assign sda_in = sda_m & ~sda_drive_low;

   always #10 clk = ~clk;

   i2c_register_slave #(.SlaveAddress(7'h48), .SyncStages(2)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .scl_in(scl_in),
      .sda_in(sda_in),
      .sda_drive_low(sda_drive_low),
      .write_strobe(write_strobe),
      .write_register(write_register),
      .write_data(write_data),
      .busy(busy)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vectors++;
      if (actual !== expected) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sendBit(input logic b);
      sda_m = b;
      waitClk(SETUP);
      scl_m = 1'b1;
      waitClk(HALF);
      scl_m = 1'b0;
      waitClk(4);
   endtask

   task automatic sendByte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) sendBit(b[i]);
      sda_m = 1'b1;
      waitClk(SETUP);
      scl_m = 1'b1;
      waitClk(HALF / 2);
      ack = sda_drive_low;
      waitClk(HALF - HALF / 2);
      scl_m = 1'b0;
      waitClk(4);
   endtask

   task automatic i2cStart();
      sda_m = 1'b1;
      waitClk(SETUP);
      scl_m = 1'b1;
      waitClk(HALF);
      sda_m = 1'b0;
      waitClk(HALF);
      scl_m = 1'b0;
      waitClk(4);
   endtask

   task automatic i2cStop();
      sda_m = 1'b0;
      waitClk(SETUP);
      scl_m = 1'b1;
      waitClk(HALF);
      sda_m = 1'b1;
      waitClk(HALF);
   endtask

   // Reference model: only a write to 0x90 produces words, one per complete byte pair.
   task automatic pushExpected(input vec_t v);
      logic [7:0]  idx;
      logic [23:0] w;
      if (v.bytes[63:56] == 8'h90 && v.nbytes >= 2) begin
         idx = v.bytes[55:48];
         for (int k = 2; k + 1 < v.nbytes; k += 2) begin
            w = {idx, v.bytes[63-8*k -: 8], v.bytes[63-8*(k+1) -: 8]};
            exp_q.push_back(w);
            last_word = w;
            idx = idx + 8'd1;
         end
      end
   endtask

   task automatic applyStimulus(input int n, input vec_t v);
      logic ack;
      i2cStart();
      checkOutput($sformatf("v%0d_busy_after_start", n), 32'(busy), 32'd1);
      pushExpected(v);
      for (int j = 0; j < v.nbytes; j++) begin
         sendByte(v.bytes[63-8*j -: 8], ack);
         checkOutput($sformatf("v%0d_ack_byte%0d", n, j), 32'(ack), 32'(v.ack_mask[j]));
      end
      i2cStop();
      waitClk(4);
      checkOutput($sformatf("v%0d_busy_after_stop", n), 32'(busy), 32'd0);
      checkOutput($sformatf("v%0d_held_word", n), {8'h00, write_register, write_data}, {8'h00, last_word});
   endtask

   always @(negedge clk) begin
      if (reset_n && write_strobe) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_strobe", {7'd0, write_strobe, write_register, write_data}, 32'd0);
         end else begin
            checkOutput("strobe_word", {8'h00, write_register, write_data}, {8'h00, exp_q.pop_front()});
         end
      end
   end

   initial begin
      logic ack;

      vecs[0] = '{4, 64'h90230033_00000000, 8'h0F};
      vecs[1] = '{4, 64'h92040011_00000000, 8'h00};
      vecs[2] = '{1, 64'h91000000_00000000, 8'h00};
      vecs[3] = '{6, 64'h900409FF_077F0000, 8'h3F};
      vecs[4] = '{3, 64'h901E4100_00000000, 8'h07};
      vecs[5] = '{4, 64'h90010038_00000000, 8'h0F};
      vecs[6] = '{6, 64'h90FF1234_56780000, 8'h3F};

      waitClk(4);
      checkOutput("reset_drive", 32'(sda_drive_low), 32'd0);
      checkOutput("reset_strobe", 32'(write_strobe), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_reg", 32'(write_register), 32'd0);
      checkOutput("reset_data", 32'(write_data), 32'd0);
      reset_n = 1'b1;
      waitClk(10);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(i, vecs[i]);
         waitClk(20);
      end

      $display("[TB] repeated START abandons a partial word");
      i2cStart();
      sendByte(8'h90, ack);
      checkOutput("rs_ack_addr", 32'(ack), 32'd1);
      sendByte(8'h10, ack);
      sendByte(8'hAA, ack);
      checkOutput("rs_ack_partial", 32'(ack), 32'd1);
      i2cStart();
      checkOutput("rs_busy", 32'(busy), 32'd1);
      exp_q.push_back({8'h20, 16'hBEEF});
      last_word = {8'h20, 16'hBEEF};
      sendByte(8'h90, ack);
      sendByte(8'h20, ack);
      sendByte(8'hBE, ack);
      sendByte(8'hEF, ack);
      checkOutput("rs_ack_last", 32'(ack), 32'd1);
      i2cStop();
      waitClk(4);
      checkOutput("rs_held_word", {8'h00, write_register, write_data}, {8'h00, last_word});
      waitClk(20);

      $display("[TB] reset while the slave holds SDA low");
      i2cStart();
      for (int i = 7; i >= 0; i--) sendBit(1'(8'h90 >> i));
      sda_m = 1'b1;
      waitClk(SETUP);
      checkOutput("rst_ack_driven", 32'(sda_drive_low), 32'd1);
      reset_n = 1'b0;
      waitClk(1);
      reset_n = 1'b1;
      checkOutput("rst_drive_cleared", 32'(sda_drive_low), 32'd0);
      checkOutput("rst_busy_cleared", 32'(busy), 32'd0);
      checkOutput("rst_word_cleared", {8'h00, write_register, write_data}, 32'd0);
      last_word = 24'h0;
      scl_m = 1'b1;
      waitClk(HALF);
      scl_m = 1'b0;
      waitClk(4);
      sendByte(8'h05, ack);
      checkOutput("rst_orphan_ack0", 32'(ack), 32'd0);
      checkOutput("rst_orphan_busy", 32'(busy), 32'd0);
      sendByte(8'h12, ack);
      checkOutput("rst_orphan_ack1", 32'(ack), 32'd0);
      sendByte(8'h34, ack);
      checkOutput("rst_orphan_ack2", 32'(ack), 32'd0);
      i2cStop();
      waitClk(4);
      checkOutput("rst_busy_end", 32'(busy), 32'd0);
      checkOutput("rst_word_end", {8'h00, write_register, write_data}, {8'h00, last_word});

      waitClk(20);
      checkOutput("pending_strobes", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
